// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one shared memory port.
// Round-robin on ties, registered memory request, combinational return path.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ifu_req_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic                ifu_ack_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_ack_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i,
    output logic [1:0]          dbg_state_o
);

    localparam int STRB_W = DATA_W / 8;

    // Handshake: a requester holds req (and its fields) high until its one-cycle ack
    // pulse; the memory side sees a registered req and answers with a one-cycle
    // mem_ack_i, which is only honoured while a grant is outstanding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IFU = 2'd1,
        GNT_LSU = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    // last_lsu resets to 1 so IFU wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        case (state_q)
            IDLE: begin
                if (ifu_req_i && lsu_req_i) begin
                    state_d    = last_lsu_q ? GNT_IFU : GNT_LSU;
                    last_lsu_d = !last_lsu_q;
                end else if (ifu_req_i) begin
                    state_d    = GNT_IFU;
                    last_lsu_d = 1'b0;
                end else if (lsu_req_i) begin
                    state_d    = GNT_LSU;
                    last_lsu_d = 1'b1;
                end
            end
            GNT_IFU, GNT_LSU: begin
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory fields latch only on the grant edge and clear on the completing ack.
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if (state_q == IDLE) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            if (state_d == GNT_IFU) begin
                mem_req_d  = 1'b1;
                mem_addr_d = ifu_addr_i;
            end else if (state_d == GNT_LSU) begin
                mem_req_d   = 1'b1;
                mem_we_d    = lsu_we_i;
                mem_addr_d  = lsu_addr_i;
                mem_wdata_d = lsu_wdata_i;
                mem_wstrb_d = lsu_wstrb_i;
            end
        end else if (mem_ack_i) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
        end
    end

    always_comb begin
        ifu_ack_o   = (state_q == GNT_IFU) && mem_ack_i;
        lsu_ack_o   = (state_q == GNT_LSU) && mem_ack_i;
        ifu_rdata_o = ifu_ack_o ? mem_rdata_i : '0;
        lsu_rdata_o = lsu_ack_o ? mem_rdata_i : '0;
        mem_req_o   = mem_req_q;
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        mem_wstrb_o = mem_wstrb_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, all checked
// against a transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              ifu_req_i = 1'b0;
    logic [ADDR_W-1:0] ifu_addr_i = '0;
    logic [DATA_W-1:0] ifu_rdata_o;
    logic              ifu_ack_o;
    logic              lsu_req_i = 1'b0;
    logic              lsu_we_i = 1'b0;
    logic [ADDR_W-1:0] lsu_addr_i = '0;
    logic [DATA_W-1:0] lsu_wdata_i = '0;
    logic [STRB_W-1:0] lsu_wstrb_i = '0;
    logic [DATA_W-1:0] lsu_rdata_o;
    logic              lsu_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [STRB_W-1:0] mem_wstrb_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              mem_ack_i = 1'b0;
    logic [1:0]        dbg_state_o;

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding transaction, owner, tie-break memory.
    bit                m_busy = 0;
    bit                m_owner_lsu = 0;
    bit                m_last_lsu = 1;
    logic              x_we = 0;
    logic [ADDR_W-1:0] x_addr = '0;
    logic [DATA_W-1:0] x_wdata = '0;
    logic [STRB_W-1:0] x_wstrb = '0;
    bit                saw_ifu_ack = 0;
    bit                saw_lsu_ack = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i),
        .ifu_rdata_o(ifu_rdata_o), .ifu_ack_o(ifu_ack_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i),
        .lsu_rdata_o(lsu_rdata_o), .lsu_ack_o(lsu_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) check("acks_exclusive", {ifu_ack_o, lsu_ack_o} == 2'b11, 1'b0);
    end

    task automatic model_clear();
        m_busy = 0;
        x_we = 0; x_addr = '0; x_wdata = '0; x_wstrb = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, mem_req_o, 0);
        check({tag, "_mem_we"}, mem_we_o, 0);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
        check({tag, "_mem_wstrb"}, mem_wstrb_o, 0);
        check({tag, "_ifu_ack"}, ifu_ack_o, 0);
        check({tag, "_ifu_rdata"}, ifu_rdata_o, 0);
        check({tag, "_lsu_ack"}, lsu_ack_o, 0);
        check({tag, "_lsu_rdata"}, lsu_rdata_o, 0);
    endtask

    // Asserts reset asynchronously (mid-cycle), checks outputs at once, releases later.
    task automatic do_reset(input string tag);
        rst_i = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        check_all_zero(tag);
        model_clear();
        m_last_lsu = 1;
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
    endtask

    // Driver step: inputs are already set; check return path, advance model, clock once.
    task automatic cycle();
        logic e_ifu, e_lsu;
        bit pick_lsu;
        #1;
        e_ifu = m_busy && !m_owner_lsu && mem_ack_i;
        e_lsu = m_busy && m_owner_lsu && mem_ack_i;
        check("ifu_ack", ifu_ack_o, e_ifu);
        check("ifu_rdata", ifu_rdata_o, e_ifu ? mem_rdata_i : '0);
        check("lsu_ack", lsu_ack_o, e_lsu);
        check("lsu_rdata", lsu_rdata_o, e_lsu ? mem_rdata_i : '0);
        saw_ifu_ack = e_ifu;
        saw_lsu_ack = e_lsu;
        if (m_busy) begin
            if (mem_ack_i) model_clear();
        end else if (ifu_req_i || lsu_req_i) begin
            pick_lsu = lsu_req_i && (!ifu_req_i || !m_last_lsu);
            m_busy = 1;
            m_owner_lsu = pick_lsu;
            m_last_lsu = pick_lsu;
            x_we    = pick_lsu ? lsu_we_i : 1'b0;
            x_addr  = pick_lsu ? lsu_addr_i : ifu_addr_i;
            x_wdata = pick_lsu ? lsu_wdata_i : '0;
            x_wstrb = pick_lsu ? lsu_wstrb_i : '0;
        end
        @(posedge clk_i);
        #1;
        check("mem_req", mem_req_o, m_busy);
        check("mem_we", mem_we_o, x_we);
        check("mem_addr", mem_addr_o, x_addr);
        check("mem_wdata", mem_wdata_o, x_wdata);
        check("mem_wstrb", mem_wstrb_o, x_wstrb);
    endtask

    initial begin
        bit ifu_pend, lsu_pend;
        int lat;

        // Reset state
        #2;
        check_all_zero("reset_initial");
        #20;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Single fetch, memory answers two cycles after the request
        ifu_req_i = 1; ifu_addr_i = 32'h100;
        cycle();
        check("fetch_req_cycle1", mem_req_o, 1);
        check("fetch_addr", mem_addr_o, 32'h100);
        cycle();
        check("fetch_we_wait", mem_we_o, 0);
        mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        check("fetch_ack", ifu_ack_o, 1);
        check("fetch_rdata", ifu_rdata_o, 32'hDEADBEEF);
        cycle();
        ifu_req_i = 0; mem_ack_i = 0;
        cycle();
        check("fetch_idle_gap", mem_req_o, 0);

        // Simultaneous requests from reset alternate IFU, LSU, IFU, LSU
        do_reset("reset_rr");
        ifu_req_i = 1; ifu_addr_i = 32'h400;
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h800;
        for (int t = 0; t < 4; t++) begin
            mem_ack_i = 0;
            cycle();
            check("rr_grant_addr", mem_addr_o, (t % 2 == 0) ? 32'h400 : 32'h800);
            mem_ack_i = 1; mem_rdata_i = $urandom;
            #1;
            check("rr_ifu_ack", ifu_ack_o, t % 2 == 0);
            check("rr_lsu_ack", lsu_ack_o, t % 2 == 1);
            cycle();
        end
        ifu_req_i = 0; lsu_req_i = 0; mem_ack_i = 0;
        cycle();

        // LSU write held until a late ack
        lsu_req_i = 1; lsu_we_i = 1; lsu_addr_i = 32'h2000;
        lsu_wdata_i = 32'h12345678; lsu_wstrb_i = 4'b0011;
        cycle();
        check("wr_we", mem_we_o, 1);
        check("wr_wstrb", mem_wstrb_o, 4'b0011);
        repeat (2) cycle();
        check("wr_held_wdata", mem_wdata_o, 32'h12345678);
        mem_ack_i = 1;
        #1;
        check("wr_lsu_ack", lsu_ack_o, 1);
        cycle();
        mem_ack_i = 0; lsu_req_i = 0;
        cycle();
        check("wr_ack_once", lsu_ack_o, 0);

        // Spurious memory ack in IDLE, then a fetch whose ack is 5 cycles late
        mem_ack_i = 1; mem_rdata_i = 32'hBAD0BAD0;
        #1;
        check("spurious_ifu_ack", ifu_ack_o, 0);
        check("spurious_lsu_ack", lsu_ack_o, 0);
        cycle();
        check("spurious_no_req", mem_req_o, 0);
        mem_ack_i = 0;
        ifu_req_i = 1; ifu_addr_i = 32'h3C0;
        cycle();
        ifu_addr_i = 32'hFFFF_0000;
        ifu_req_i = 0;
        repeat (5) cycle();
        check("late_addr_held", mem_addr_o, 32'h3C0);
        mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
        #1;
        check("dropped_req_still_acked", ifu_ack_o, 1);
        cycle();
        mem_ack_i = 0;
        cycle();

        // Reset while LSU waits; pending fetch wins afterwards
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h5000;
        cycle();
        ifu_req_i = 1; ifu_addr_i = 32'h300;
        cycle();
        do_reset("reset_mid_lsu");
        cycle();
        check("post_reset_ifu_first", mem_addr_o, 32'h300);
        mem_ack_i = 1;
        cycle();
        ifu_req_i = 0; lsu_req_i = 0; mem_ack_i = 0;
        cycle();

        // Randomized traffic
        ifu_pend = 0; lsu_pend = 0; lat = 0;
        for (int n = 0; n < 600; n++) begin
            if (saw_ifu_ack) ifu_pend = 0;
            if (saw_lsu_ack) lsu_pend = 0;
            if (!ifu_pend && $urandom_range(0, 2) == 0) begin
                ifu_pend = 1;
                ifu_addr_i = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1;
                lsu_we_i = 1'($urandom_range(0, 1));
                lsu_addr_i = $urandom;
                lsu_wdata_i = $urandom;
                lsu_wstrb_i = 4'($urandom_range(0, 15));
            end
            ifu_req_i = ifu_pend;
            lsu_req_i = lsu_pend;
            mem_rdata_i = $urandom;
            if (mem_req_o) begin
                if (lat == 0) mem_ack_i = 1;
                else begin
                    lat--;
                    mem_ack_i = 0;
                end
            end else begin
                mem_ack_i = ($urandom_range(0, 7) == 0);
                lat = $urandom_range(0, 3);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
